// File: rtl/alu_exec_mc_if.sv
// alu_exec_mc_if: command/result bundle for the multi-cycle EX-stage ALU.
// Master (controller) drives: start, aluop, func_code, a, b, shamt.
// Slave (alu_exec_mc) drives: result, zero, ovf, illegal, busy, done, hi, lo.
interface alu_exec_mc_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             start;
    logic [1:0]       aluop;
    logic [5:0]       func_code;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (
        output start, aluop, func_code, a, b, shamt,
        input  result, zero, ovf, illegal, busy, done, hi, lo
    );
    modport slave (
        input  start, aluop, func_code, a, b, shamt,
        output result, zero, ovf, illegal, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_exec_mc.sv
// alu_exec_mc: EX-stage ALU with internal aluop/funct decode, registered
// single-cycle results and iterative multu/divu into HI/LO.
// Ports: clk (rising edge), rst_n (synchronous, active low),
//        bus (alu_exec_mc_if.slave): start/aluop/func_code/a/b/shamt in,
//        result/zero/ovf/illegal/busy/done/hi/lo out.
module alu_exec_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_exec_mc_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    // acc: product high half / partial remainder; sh: multiplier / dividend-quotient; opd: multiplicand / divisor
    logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opd_q, opd_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, illegal_q, illegal_d, done_q, done_d;
    logic [5:0]       fn;
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf, alu_ill, is_mul, is_div;
    logic [WIDTH:0]   madd, dsh, dtrial;
    logic             ge;
    // aluop 00/10 are aliases of funct add/sub
    assign fn   = bus.aluop[0] ? bus.func_code : {4'b1000, bus.aluop[1], 1'b0};
    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        case (fn)
            6'b100000: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            6'b100001: alu_res = sum;
            6'b100010: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            6'b100011: alu_res = diff;
            6'b100100: alu_res = bus.a & bus.b;
            6'b100101: alu_res = bus.a | bus.b;
            6'b100110: alu_res = bus.a ^ bus.b;
            6'b100111: alu_res = ~(bus.a | bus.b);
            6'b101010: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            6'b101011: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            6'b000000: alu_res = bus.b << bus.shamt;
            6'b000010: alu_res = bus.b >> bus.shamt;
            6'b000011: alu_res = $signed(bus.b) >>> bus.shamt;
            6'b010000: alu_res = hi_q;
            6'b010010: alu_res = lo_q;
            6'b011001: is_mul = 1'b1;
            6'b011011: is_div = 1'b1;
            default:   alu_ill = 1'b1;
        endcase
    end
    // shift-add step: conditionally add multiplicand to the high half, then shift the pair right
    assign madd   = {1'b0, acc_q} + ({(WIDTH+1){sh_q[0]}} & {1'b0, opd_q});
    // restoring step: shift next dividend bit into the remainder and trial-subtract the divisor
    assign dsh    = {acc_q, sh_q[WIDTH-1]};
    assign dtrial = dsh - {1'b0, opd_q};
    assign ge     = ~dtrial[WIDTH];
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        opd_d     = opd_q;
        case (state_q)
            IDLE: begin
                if (bus.start && (is_mul || is_div)) begin
                    state_d   = is_mul ? MUL : DIV;
                    cnt_d     = '0;
                    acc_d     = '0;
                    sh_d      = is_mul ? bus.b : bus.a;
                    opd_d     = is_mul ? bus.a : bus.b;
                    result_d  = '0;
                    zero_d    = 1'b1;
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                end else if (bus.start) begin
                    result_d  = alu_res;
                    zero_d    = alu_res == '0;
                    ovf_d     = alu_ovf;
                    illegal_d = alu_ill;
                    done_d    = 1'b1;
                end
            end
            MUL, DIV: begin
                acc_d = (state_q == MUL) ? madd[WIDTH:1] : (ge ? dtrial[WIDTH-1:0] : dsh[WIDTH-1:0]);
                sh_d  = (state_q == MUL) ? {madd[0], sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    hi_d    = acc_d;
                    lo_d    = sh_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            opd_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            opd_q     <= opd_d;
        end
    end
    assign bus.result  = result_q;
    assign bus.zero    = zero_q;
    assign bus.ovf     = ovf_q;
    assign bus.illegal = illegal_q;
    assign bus.busy    = state_q != IDLE;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule

// File: doc/alu_exec_mc.md
Name: alu_exec_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU control decoder.
- Decodes the main-control aluop plus the full 6-bit R-type funct field internally, then executes the operation.
- Single-cycle ops: registered result. multu/divu: iterative, with HI/LO registers.
- Sits in the EX stage of the multi-cycle datapath. Controller drives start and waits for done.

Parameters:
WIDTH, 32, datapath width (power of two, >= 8)
SHW, $clog2(WIDTH), shift-amount width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  launch operation; sampled only when busy=0
aluop  input  2  00 add, 10 sub, x1 decode func_code
func_code  input  6  R-type funct field
a  input  WIDTH  operand rs
b  input  WIDTH  operand rt
shamt  input  SHW  shift amount
result  output  WIDTH  registered result
zero  output  1  result==0, registered with result
ovf  output  1  signed overflow (add/sub only)
illegal  output  1  undefined funct
busy  output  1  iterative op in progress
done  output  1  one-cycle completion pulse
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0, HI=LO=0, state IDLE. Reset mid-op aborts it; HI/LO are not updated.
- Funct map:
  - 100000 add, 100001 addu, 100010 sub, 100011 subu
  - 100100 and, 100101 or, 100110 xor, 100111 nor
  - 101010 slt (signed), 101011 sltu
  - 000000 sll, 000010 srl, 000011 sra (b shifted by shamt)
  - 010000 mfhi, 010010 mflo
  - 011001 multu, 011011 divu
  - Any other funct with aluop[0]=1: illegal=1, result=0, done pulse, HI/LO unchanged.
- aluop 00/10 behave exactly as funct add/sub. aluop[0]=1 ignores aluop[1].
- Arithmetic: all WIDTH-bit modulo.
  - ovf=1 only for add/sub (funct or aluop 00/10) on signed overflow; 0 for all other ops.
  - slt/sltu result is zero-extended 1/0.
  - sra replicates b[WIDTH-1].
- FSM states IDLE, MUL, DIV.
- IDLE, start=1, single-cycle op:
  - result/zero/ovf/illegal update at that edge.
  - done=1 for exactly the following cycle. Latency 1.
  - Back-to-back starts every cycle are legal.
- IDLE, start=1, multu/divu:
  - Latch operands, busy=1 from next cycle, counter=0.
  - Go to MUL or DIV.
- MUL: shift-add, one bit per cycle, WIDTH iterations.
- DIV: restoring, one quotient bit per cycle, WIDTH iterations.
- After the last iteration:
  - HI/LO written (MUL: HI=upper, LO=lower 2*WIDTH product; DIV: LO=quotient, HI=remainder).
  - busy=0, done=1 for one cycle, return to IDLE.
  - Total latency start-edge to done = WIDTH+1 cycles.
  - result=0, zero=1, ovf=0, illegal=0 for multu/divu.
- divu by zero: no special path. Completes in the same latency with LO = all ones, HI = a.
- start while busy=1 is ignored; no queueing, no error.
- mfhi/mflo return HI/LO as of the issuing edge. Back-to-back mfhi after the multu done cycle sees the new value.
- Outputs hold between operations; done is 0 except the pulse cycle.
- Operand inputs may change freely after the start edge.

Test Plan:
- Reset mid-op: start multu, a=5, b=7; rst_n=0 at cycle 10 -> next cycle busy=0, done=0, HI=LO=0, result=0; a subsequent start is accepted.
- Single-cycle sweep (WIDTH=32):
  - add 0x7FFFFFFF+1 -> result 0x80000000, ovf=1.
  - sub 5-5 -> result 0, zero=1.
  - slt -1<1 -> 1; sltu 0xFFFFFFFF<1 -> 0.
  - sra 0x80000000 by 4 -> 0xF8000000.
  - nor 0,0 -> 0xFFFFFFFF.
  - Each done exactly 1 cycle after start; starts on consecutive cycles all complete.
- Illegal and aluop: funct 111111 with aluop 01 -> illegal=1, result 0. aluop 10 with funct 111111 -> sub executed, illegal=0.
- multu 0xFFFFFFFF*0xFFFFFFFF -> done at start+33, HI=0xFFFFFFFE, LO=0x00000001. busy high cycles 1-32. A start at cycle 5 is ignored. mfhi next -> 0xFFFFFFFE.
- divu 100/7 -> LO=14, HI=2 at start+33. divu 9/0 -> LO=0xFFFFFFFF, HI=9, same latency.
- Parametric: WIDTH=8, multu 0xFF*0x02 -> HI=0x01, LO=0xFE, done at start+9.
